// File: rtl/wb_stream_writer_pkg.sv
// Shared types for the stream-to-Wishbone writer.
package wb_stream_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_BUS       = 2'd2,
        ST_FINISH    = 2'd3
    } state_t;

endpackage

// File: rtl/wb_stream_writer.sv
// Wishbone classic master that writes a counted run of stream words to
// consecutive word addresses, one bus cycle in flight at a time.
module wb_stream_writer
    import wb_stream_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [COUNT_WIDTH-1:0]  word_count,
    output logic                    busy,
    output logic                    done,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    we_o,
    output logic [SELECT_WIDTH-1:0] sel_o,
    output logic                    stb_o,
    output logic                    cyc_o,
    input  logic                    ack_i
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(SELECT_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(SELECT_WIDTH - 1);

    state_t                  r_state, w_state;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr;
    logic [COUNT_WIDTH-1:0]  r_remaining, w_remaining;
    logic                    r_busy, w_busy;
    logic                    r_done, w_done;
    logic                    r_tready, w_tready;
    logic                    r_cyc, w_cyc;
    logic [SELECT_WIDTH-1:0] r_sel, w_sel;
    logic [ADDR_WIDTH-1:0]   r_adr, w_adr;
    logic [DATA_WIDTH-1:0]   r_dat, w_dat;

    // State and datapath registers; reset clears the bus strobes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_tready    <= 1'b0;
            r_cyc       <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
        end else begin
            r_state     <= w_state;
            r_addr      <= w_addr;
            r_remaining <= w_remaining;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_tready    <= w_tready;
            r_cyc       <= w_cyc;
            r_sel       <= w_sel;
            r_adr       <= w_adr;
            r_dat       <= w_dat;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_addr      = r_addr;
        w_remaining = r_remaining;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_tready    = r_tready;
        w_cyc       = r_cyc;
        w_adr       = r_adr;
        w_dat       = r_dat;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        w_addr      = base_addr & ADDR_MASK;
                        w_remaining = word_count;
                        w_busy      = 1'b1;
                        w_tready    = 1'b1;
                        w_state     = ST_WAIT_DATA;
                    end else begin
                        w_state = ST_FINISH;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (s_tvalid && r_tready) begin
                    w_dat    = s_tdata;
                    w_adr    = r_addr;
                    w_cyc    = 1'b1;
                    w_tready = 1'b0;
                    w_state  = ST_BUS;
                end
            end
            ST_BUS: begin
                // Dropping the strobe on the ack edge guarantees a low cycle before the next write.
                if (ack_i) begin
                    w_cyc       = 1'b0;
                    w_addr      = r_addr + ADDR_STEP;
                    w_remaining = r_remaining - COUNT_WIDTH'(1);
                    if (r_remaining == COUNT_WIDTH'(1)) begin
                        w_state = ST_FINISH;
                    end else begin
                        w_tready = 1'b1;
                        w_state  = ST_WAIT_DATA;
                    end
                end
            end
            ST_FINISH: begin
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = ST_IDLE;
            end
            default: w_state = ST_IDLE;
        endcase

        w_sel = {SELECT_WIDTH{w_cyc}};
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign s_tready = r_tready;
    assign adr_o    = r_adr;
    assign dat_o    = r_dat;
    assign we_o     = r_cyc;
    assign stb_o    = r_cyc;
    assign cyc_o    = r_cyc;
    assign sel_o    = r_sel;

endmodule

// File: tb/tb_wb_stream_writer.sv
// Directed bench for wb_stream_writer with a registered-ack RAM model.
module tb_wb_stream_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] adr_o;
    logic [31:0] dat_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic        stb_o;
    logic        cyc_o;
    logic        ack_i;

    wb_stream_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .adr_o      (adr_o),
        .dat_o      (dat_o),
        .we_o       (we_o),
        .sel_o      (sel_o),
        .stb_o      (stb_o),
        .cyc_o      (cyc_o),
        .ack_i      (ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // RAM slave: ack is registered and appears ack_delay cycles late.
    logic [31:0] mem [0:16383];
    int ack_delay = 0;
    int wait_cnt  = 0;
    always @(posedge clk) begin
        ack_i <= 1'b0;
        if (cyc_o && stb_o && !ack_i) begin
            if (wait_cnt >= ack_delay) begin
                ack_i <= 1'b1;
                mem[adr_o[15:2]] <= dat_o;
                wait_cnt <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else if (!stb_o) begin
            wait_cnt <= 0;
        end
    end

    // Bus monitor: counts events from pre-edge values.
    int hs_cnt = 0, acks = 0, done_cnt = 0, busy_cnt = 0, cyc_starts = 0;
    int cyc_hi = 0, stb_hi = 0, unstable = 0, stb_after_ack = 0;
    logic [15:0] adr_log [0:63];
    logic        cyc_q = 1'b0, stb_q = 1'b0, ack_q = 1'b0;
    logic [15:0] adr_q = '0;
    logic [31:0] dat_q = '0;
    always @(posedge clk) begin
        if (s_tvalid && s_tready) hs_cnt++;
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (cyc_o) cyc_hi++;
        if (stb_o) stb_hi++;
        if (cyc_o && !cyc_q) cyc_starts++;
        if (cyc_o && stb_o && ack_i) begin
            if (acks < 64) adr_log[acks] = adr_o;
            acks++;
        end
        if (stb_o && stb_q && (adr_o !== adr_q || dat_o !== dat_q)) unstable++;
        if (ack_q && stb_o) stb_after_ack++;
        cyc_q = cyc_o;
        stb_q = stb_o;
        ack_q = ack_i;
        adr_q = adr_o;
        dat_q = dat_o;
    end

    // Stream source: holds valid until accepted, optionally only on every src_gap-th cycle.
    logic [31:0] src_data [0:7];
    int src_base = 0, src_len = 0, src_gap = 0;
    initial begin : src_proc
        int phase;
        int hs_at;
        int idx;
        phase    = 0;
        hs_at    = 0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        forever begin
            @(negedge clk);
            phase++;
            if (s_tvalid && hs_cnt != hs_at) s_tvalid = 1'b0;
            idx = hs_cnt - src_base;
            if (idx >= src_len) begin
                s_tvalid = 1'b0;
            end else if (!s_tvalid && (src_gap == 0 || (phase % src_gap) == 0)) begin
                s_tvalid = 1'b1;
                s_tdata  = src_data[idx];
                hs_at    = hs_cnt;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulses start from posedge+1; n counts edges from the sampling edge (n=1) to done seen.
    task automatic run_start(input string tag, input logic [15:0] b, input logic [15:0] c,
                             output int n, output logic busy_at1);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        n          = 0;
        busy_at1   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                start    = 1'b0;
                busy_at1 = busy;
            end
            if (done) break;
        end
        check({tag, "_done_seen"}, 64'(done), 64'd1);
    endtask

    int n, b_ack, b_done, b_cyc, b_busy, b_cychi, b_stbhi, b_hs;
    logic busy1;

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   64'(busy),     64'd0);
        check("rst_done",   64'(done),     64'd0);
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_cyc",    64'(cyc_o),    64'd0);
        check("rst_stb",    64'(stb_o),    64'd0);
        check("rst_we",     64'(we_o),     64'd0);
        check("rst_sel",    64'(sel_o),    64'd0);
        check("rst_adr",    64'(adr_o),    64'd0);
        check("rst_dat",    64'(dat_o),    64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_tready", 64'(s_tready), 64'd0);

        // Four back-to-back words, zero-wait slave: 3 clocks per word.
        src_data[0] = 32'hA0; src_data[1] = 32'hA1; src_data[2] = 32'hA2; src_data[3] = 32'hA3;
        src_gap = 0; src_base = hs_cnt; src_len = 4;
        b_ack = acks; b_done = done_cnt; b_cyc = cyc_starts;
        run_start("t1", 16'h0010, 16'd4, n, busy1);
        check("t1_busy_lat", 64'(busy1), 64'd1);
        check("t1_latency",  64'(n),     64'd14);
        check("t1_busy_off", 64'(busy),  64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("t1_done_once", 64'(done_cnt - b_done), 64'd1);
        check("t1_acks",      64'(acks - b_ack),      64'd4);
        check("t1_cycs",      64'(cyc_starts - b_cyc), 64'd4);
        check("t1_adr0", 64'(adr_log[b_ack]),     64'h0010);
        check("t1_adr1", 64'(adr_log[b_ack + 1]), 64'h0014);
        check("t1_adr2", 64'(adr_log[b_ack + 2]), 64'h0018);
        check("t1_adr3", 64'(adr_log[b_ack + 3]), 64'h001C);
        check("t1_mem0", 64'(mem[14'h0004]), 64'hA0);
        check("t1_mem1", 64'(mem[14'h0005]), 64'hA1);
        check("t1_mem2", 64'(mem[14'h0006]), 64'hA2);
        check("t1_mem3", 64'(mem[14'h0007]), 64'hA3);

        // Zero-length transfer: done only, no bus or busy activity.
        b_done = done_cnt; b_cyc = cyc_starts; b_busy = busy_cnt;
        run_start("t2", 16'h0020, 16'd0, n, busy1);
        check("t2_latency", 64'(n), 64'd2);
        repeat (2) @(posedge clk);
        #1;
        check("t2_busy_never", 64'(busy_cnt - b_busy),  64'd0);
        check("t2_no_cyc",     64'(cyc_starts - b_cyc), 64'd0);
        check("t2_done_once",  64'(done_cnt - b_done),  64'd1);

        // Slow slave: ack 5 cycles late, outputs must hold.
        ack_delay = 5;
        src_data[0] = 32'h1111_1111; src_data[1] = 32'h2222_2222;
        src_base = hs_cnt; src_len = 2;
        b_ack = acks; b_stbhi = stb_hi; b_done = done_cnt;
        run_start("t3", 16'h0100, 16'd2, n, busy1);
        check("t3_latency", 64'(n), 64'd18);
        repeat (2) @(posedge clk);
        #1;
        check("t3_acks",     64'(acks - b_ack),     64'd2);
        check("t3_stb_hi",   64'(stb_hi - b_stbhi), 64'd14);
        check("t3_stable",   64'(unstable),         64'd0);
        check("t3_done",     64'(done_cnt - b_done), 64'd1);
        check("t3_mem0", 64'(mem[14'h0040]), 64'h1111_1111);
        check("t3_mem1", 64'(mem[14'h0041]), 64'h2222_2222);
        ack_delay = 0;

        // Gapped stream: bus idles while data is absent.
        src_data[0] = 32'hC0; src_data[1] = 32'hC1; src_data[2] = 32'hC2;
        src_gap = 4; src_base = hs_cnt; src_len = 3;
        b_ack = acks; b_cychi = cyc_hi; b_hs = hs_cnt;
        run_start("t4", 16'h0200, 16'd3, n, busy1);
        repeat (2) @(posedge clk);
        #1;
        check("t4_hs",     64'(hs_cnt - b_hs),    64'd3);
        check("t4_cyc_hi", 64'(cyc_hi - b_cychi), 64'd6);
        check("t4_adr2",   64'(adr_log[b_ack + 2]), 64'h0208);
        check("t4_mem0", 64'(mem[14'h0080]), 64'hC0);
        check("t4_mem1", 64'(mem[14'h0081]), 64'hC1);
        check("t4_mem2", 64'(mem[14'h0082]), 64'hC2);
        src_gap = 0;

        // Address wraps past the top of the 64 KiB space.
        src_data[0] = 32'hDEAD_0001; src_data[1] = 32'hDEAD_0002;
        src_base = hs_cnt; src_len = 2;
        b_ack = acks;
        run_start("t5", 16'hFFFC, 16'd2, n, busy1);
        repeat (2) @(posedge clk);
        #1;
        check("t5_adr0", 64'(adr_log[b_ack]),     64'hFFFC);
        check("t5_adr1", 64'(adr_log[b_ack + 1]), 64'h0000);
        check("t5_mem0", 64'(mem[14'h3FFF]), 64'hDEAD_0001);
        check("t5_mem1", 64'(mem[14'h0000]), 64'hDEAD_0002);

        // Unaligned base: low two bits are cleared.
        src_data[0] = 32'h0000_3300;
        src_base = hs_cnt; src_len = 1;
        b_ack = acks;
        run_start("t6", 16'h0033, 16'd1, n, busy1);
        check("t6_latency", 64'(n), 64'd5);
        @(posedge clk);
        #1;
        check("t6_adr",  64'(adr_log[b_ack]), 64'h0030);
        check("t6_mem",  64'(mem[14'h000C]), 64'h0000_3300);

        // Reset mid-cycle drops the strobe without a clock edge.
        ack_delay = 20;
        src_data[0] = 32'h7777_0000; src_data[1] = 32'h7777_0001;
        src_base = hs_cnt; src_len = 2;
        b_done = done_cnt;
        base_addr = 16'h0400; word_count = 16'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (stb_o) break;
            @(posedge clk);
            #1;
        end
        check("t7_stb_before", 64'(stb_o), 64'd1);
        src_len = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_cyc_async", 64'(cyc_o), 64'd0);
        check("t7_stb_async", 64'(stb_o), 64'd0);
        check("t7_busy_async", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ack_delay = 0;
        @(posedge clk);
        #1;
        check("t7_idle_tready", 64'(s_tready), 64'd0);
        check("t7_idle_busy",   64'(busy),     64'd0);
        check("t7_no_done",     64'(done_cnt - b_done), 64'd0);

        src_data[0] = 32'h0000_55AA;
        src_base = hs_cnt; src_len = 1;
        b_done = done_cnt;
        run_start("t8", 16'h0500, 16'd1, n, busy1);
        check("t8_latency", 64'(n), 64'd5);
        repeat (2) @(posedge clk);
        #1;
        check("t8_mem",  64'(mem[14'h0140]), 64'h0000_55AA);
        check("t8_done", 64'(done_cnt - b_done), 64'd1);
        check("stb_after_ack", 64'(stb_after_ack), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
